// File: rtl/mem_responder.sv
// Memory-side responder: word-addressed RAM behind MAR/MDR with programmable wait states and a done/mdr_load handshake.
// Define MEM_PARITY_EN to add per-word even parity plus the inject_parity_err input.

module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef MEM_PARITY_EN
  input  logic              inject_parity_err,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              mdr_load,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_DONE   = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  state_t            state_r, state_s;
  logic [3:0]        cnt_r, cnt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              wr_op_r;
  logic [DATA_W-1:0] rdata_r;
  logic              mdr_load_r, busy_r, done_r, err_r;

  logic              accept_s, dual_s, in_range_s, par_bad_s;
  logic              mem_we_s, rd_upd_s, mdr_load_s, err_s;
  logic [DATA_W-1:0] mem_rd_s, rdata_s;
  logic [IDX_W-1:0]  idx_s;

  logic [DATA_W-1:0] mem_r [DEPTH];

  assign idx_s      = addr_r[IDX_W-1:0];
  assign in_range_s = ({1'b0, addr_r} < DEPTH_L);
  assign mem_rd_s   = mem_r[idx_s];

`ifdef MEM_PARITY_EN
  logic par_r [DEPTH];
  logic par_wr_s;

  assign par_wr_s  = even_parity(wdata_r) ^ inject_parity_err;
  assign par_bad_s = (even_parity(mem_rd_s) != par_r[idx_s]);

  // Parity bit storage, written alongside the data word.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      par_r[idx_s] <= par_wr_s;
    end
  end
`else
  assign par_bad_s = 1'b0;
`endif

  // Next-state logic for the request handshake.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    dual_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_read ^ mem_write) begin
          accept_s = 1'b1;
          if (WAIT_L == 4'd0) begin
            state_s = ST_ACCESS;
          end else begin
            state_s = ST_WAIT;
            cnt_s   = WAIT_L;
          end
        end else if (mem_read && mem_write) begin
          dual_s  = 1'b1;
          state_s = ST_DONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_s = cnt_r - 4'd1;
        // A zero count here can only come from corruption; leave rather than wrap.
        if (cnt_r <= 4'd1) begin
          state_s = ST_ACCESS;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_ACCESS: state_s = ST_DONE;
      ST_DONE:   state_s = ST_HOLD;
      ST_HOLD: begin
        if (mem_read || mem_write) begin
          state_s = ST_HOLD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Array access decode and next values for the registered outputs.
  always_comb begin
    mem_we_s   = 1'b0;
    rd_upd_s   = 1'b0;
    mdr_load_s = 1'b0;
    err_s      = 1'b0;
    rdata_s    = rdata_r;
    if (state_r == ST_ACCESS) begin
      if (!in_range_s) begin
        err_s = 1'b1;
        if (!wr_op_r) begin
          rd_upd_s = 1'b1;
          rdata_s  = {DATA_W{1'b0}};
        end else begin
          rd_upd_s = 1'b0;
        end
      end else if (wr_op_r) begin
        mem_we_s = 1'b1;
      end else begin
        rd_upd_s   = 1'b1;
        rdata_s    = mem_rd_s;
        mdr_load_s = 1'b1;
        err_s      = par_bad_s;
      end
    end else if (dual_s) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  // Control state, request latches and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      wr_op_r    <= 1'b0;
      rdata_r    <= {DATA_W{1'b0}};
      mdr_load_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        addr_r  <= addr;
        wdata_r <= wdata;
        wr_op_r <= mem_write;
      end
      if (rd_upd_s) begin
        rdata_r <= rdata_s;
      end
      mdr_load_r <= mdr_load_s;
      err_r      <= err_s;
      done_r     <= (state_s == ST_DONE);
      busy_r     <= (state_s != ST_IDLE);
    end
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[idx_s] <= wdata_r;
    end
  end

  assign rdata    = rdata_r;
  assign mdr_load = mdr_load_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

  mem_responder_chk u_chk (
    .clk      (clk),
    .clr      (clr),
    .done     (done_r),
    .err      (err_r),
    .mdr_load (mdr_load_r),
    .busy     (busy_r)
  );

endmodule

// Handshake invariants of the responder outputs.
module mem_responder_chk (
  input logic clk,
  input logic clr,
  input logic done,
  input logic err,
  input logic mdr_load,
  input logic busy
);
  a_err_with_done: assert property (@(posedge clk) disable iff (!clr) err |-> done);
  a_mdr_with_done: assert property (@(posedge clk) disable iff (!clr) mdr_load |-> done);
  a_done_busy:     assert property (@(posedge clk) disable iff (!clr) done |-> busy);
  a_done_single:   assert property (@(posedge clk) disable iff (!clr) done |=> !done);
endmodule
